// File: rtl/tx_fifo_if.sv
// Push/pop/status bundle between the AES stage, the TX FIFO and its word consumer.
interface tx_fifo_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             write_enable;
  logic [127:0]     write_data;
  logic             clear;
  logic             read_word;
  logic [31:0]      read_data;
  logic             tx_fifo_full;
  logic             empty;
  logic [CNT_W-1:0] block_count;
  logic             overflow;
  logic             underflow;

  modport master (
    output write_enable, write_data, clear, read_word,
    input  read_data, tx_fifo_full, empty, block_count, overflow, underflow
  );

  modport slave (
    input  write_enable, write_data, clear, read_word,
    output read_data, tx_fifo_full, empty, block_count, overflow, underflow
  );
endinterface

// File: rtl/tx_fifo.sv
// Block-in / word-out FIFO: accepts 128-bit blocks, emits them as four 32-bit
// words, most significant word first.
module tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      n_rst,
  tx_fifo_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [127:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [1:0]       word_idx;
  logic [CNT_W-1:0] block_count;
  logic             overflow;
  logic             underflow;

  logic full;
  logic empty;
  logic push_ok;
  logic pop_ok;
  logic block_done;

  // Status derives from the registered count, so a pop on the same edge
  // cannot make room for a push that arrives while full.
  assign full       = (block_count == CNT_W'(DEPTH));
  assign empty      = (block_count == '0);
  assign push_ok    = bus.write_enable && !full  && !bus.clear;
  assign pop_ok     = bus.read_word    && !empty && !bus.clear;
  assign block_done = pop_ok && (word_idx == 2'd3);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      word_idx    <= '0;
      block_count <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else if (bus.clear) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      word_idx    <= '0;
      block_count <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)
        word_idx <= word_idx + 2'd1;
      if (block_done)
        rd_ptr <= rd_ptr + PTR_W'(1);

      case ({push_ok, block_done})
        2'b10:   block_count <= block_count + CNT_W'(1);
        2'b01:   block_count <= block_count - CNT_W'(1);
        default: block_count <= block_count;
      endcase

      if (bus.write_enable && full)
        overflow <= 1'b1;
      if (bus.read_word && empty)
        underflow <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; the control state above already
  // makes stale contents unreachable, and resetting it would only add fan-out.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= bus.write_data;
  end

  // NOTE: read_data gets a default before any branch so no latch is inferred.
  always_comb begin
    bus.read_data = 32'h0;
    if (!empty) begin
      case (word_idx)
        2'd0:    bus.read_data = mem[rd_ptr][127:96];
        2'd1:    bus.read_data = mem[rd_ptr][95:64];
        2'd2:    bus.read_data = mem[rd_ptr][63:32];
        default: bus.read_data = mem[rd_ptr][31:0];
      endcase
    end
  end

  assign bus.tx_fifo_full = full;
  assign bus.empty        = empty;
  assign bus.block_count  = block_count;
  assign bus.overflow     = overflow;
  assign bus.underflow    = underflow;
endmodule
